pixel_readout_ctrl: RTL and testbench

- Parametrised frame sequencer and row readout for a W x H pixel array with DW-bit in-pixel ADC.
- Runs erase -> expose -> ramp-convert, snapshots the array's parallel data bus into a frame buffer, and streams it out one row per beat over a valid/ready handshake.
- Sits between the pixel array and the downstream image pipeline.
- Supports single-shot and continuous frame modes.

---
 rtl/pixel_readout_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer (erase/expose/ramp-convert/latch) and row-per-beat readout of a W x H pixel array.
// Latency: start -> erase next cycle; rows stream without bubbles, stalling on !out_ready. Option: PIXEL_READOUT_TESTPATTERN_EN.
module pixel_readout_ctrl #(
    parameter int W          = 25,
    parameter int H          = 10,
    parameter int DW         = 8,
    parameter int ERASE_CYC  = 5,
    parameter int EXPOSE_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
`ifdef PIXEL_READOUT_TESTPATTERN_EN
    input  logic                  test_mode,
`endif
    input  logic [W*H*DW-1:0]     pix_data,
    output logic                  pix_erase,
    output logic                  pix_expose,
    output logic                  pix_convert,
    output logic [DW-1:0]         ramp_code,
    output logic [W*DW-1:0]       out_data,
    output logic [$clog2(H)-1:0]  out_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int RW       = $clog2(H);
    localparam int CONV_CYC = 2 ** DW;
    localparam int CYC_MAX  = (ERASE_CYC > EXPOSE_CYC)
                              ? ((ERASE_CYC > CONV_CYC) ? ERASE_CYC : CONV_CYC)
                              : ((EXPOSE_CYC > CONV_CYC) ? EXPOSE_CYC : CONV_CYC);
    localparam int CW       = $clog2(CYC_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_LATCH, S_READOUT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       row_q, row_d;
    logic                erase_q, erase_d;
    logic                expose_q, expose_d;
    logic                convert_q, convert_d;
    logic [DW-1:0]       ramp_q, ramp_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [W*H*DW-1:0]   frame_q, frame_d;
    logic [W*DW-1:0]     row_dat;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
    logic [DW-1:0]       fcnt_q, fcnt_d;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:    if (start) state_d = S_ERASE;
            S_ERASE:   if (cnt_q == CW'(ERASE_CYC - 1)) state_d = S_EXPOSE;
            S_EXPOSE:  if (cnt_q == CW'(EXPOSE_CYC - 1)) state_d = S_CONVERT;
            S_CONVERT: if (cnt_q == CW'(CONV_CYC - 1)) state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_READOUT;
                row_d   = '0;
            end
            S_READOUT: begin
                if (out_ready) begin
                    if (row_q == RW'(H - 1)) begin
                        done_d  = 1'b1;
                        row_d   = '0;
                        state_d = continuous ? S_ERASE : S_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One shared counter, restarted on every state change; it doubles as the ramp.
        cnt_d     = (state_d != state_q) ? '0 : cnt_q + CW'(1);
        erase_d   = (state_d == S_ERASE);
        expose_d  = (state_d == S_EXPOSE);
        convert_d = (state_d == S_CONVERT);
        ramp_d    = (state_d == S_CONVERT) ? cnt_d[DW-1:0] : '0;
        valid_d   = (state_d == S_READOUT);
        last_d    = (state_d == S_READOUT) && (row_d == RW'(H - 1));
        busy_d    = (state_d != S_IDLE);
        frame_d   = (state_q == S_LATCH) ? pix_data : frame_q;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
        fcnt_d    = done_d ? fcnt_q + DW'(1) : fcnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            ramp_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
            fcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            convert_q <= convert_d;
            ramp_q    <= ramp_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PIXEL_READOUT_TESTPATTERN_EN
            fcnt_q    <= fcnt_d;
`endif
        end
    end

    // Snapshot storage has no reset; its contents only matter after a LATCH.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    always_comb begin
        row_dat = '0;
        for (int r = 0; r < H; r++) begin
            if (valid_q && row_q == RW'(r)) row_dat = frame_q[r*W*DW +: W*DW];
        end
`ifdef PIXEL_READOUT_TESTPATTERN_EN
        if (valid_q && test_mode) begin
            for (int c = 0; c < W; c++) row_dat[c*DW +: DW] = DW'(row_q) + DW'(c) + fcnt_q;
        end
`endif
    end

    assign pix_erase   = erase_q;
    assign pix_expose  = expose_q;
    assign pix_convert = convert_q;
    assign ramp_code   = ramp_q;
    assign out_data    = row_dat;
    assign out_row     = row_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl: per-cycle sequencing model plus a row-beat scoreboard.
module tb_pixel_readout_ctrl;
    localparam int W = 4, H = 3, DW = 4, ERASE_CYC = 2, EXPOSE_CYC = 3;
    localparam int RW = $clog2(H);
    localparam int T_EXP  = 1 + ERASE_CYC;
    localparam int T_CONV = T_EXP + EXPOSE_CYC;
    localparam int T_LATCH = T_CONV + 2 ** DW;
    localparam int T_RD   = T_LATCH + 1;
    localparam int T_DONE = T_RD + H;
    localparam int FRAME_PERIOD = ERASE_CYC + EXPOSE_CYC + 2 ** DW + 1 + H;

    typedef logic [W*H*DW-1:0] img_t;
    typedef struct packed {
        logic [RW-1:0]   row;
        logic            last;
        logic [W*DW-1:0] dat;
    } beat_t;

    logic clk, reset, start, continuous, test_mode, out_ready;
    img_t pix_data;
    logic pix_erase, pix_expose, pix_convert, out_valid, out_last, busy, frame_done;
    logic [DW-1:0]   ramp_code;
    logic [W*DW-1:0] out_data;
    logic [RW-1:0]   out_row;

    int    checks = 0;
    int    errors = 0;
    int    beats  = 0;
    beat_t sb_q[$];
    logic  stall_p = 1'b0;
    logic [W*DW+RW+1:0] snap = '0;

    pixel_readout_ctrl #(.W(W), .H(H), .DW(DW), .ERASE_CYC(ERASE_CYC), .EXPOSE_CYC(EXPOSE_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
`ifdef PIXEL_READOUT_TESTPATTERN_EN
        .test_mode(test_mode),
`endif
        .pix_data(pix_data), .pix_erase(pix_erase), .pix_expose(pix_expose),
        .pix_convert(pix_convert), .ramp_code(ramp_code), .out_data(out_data),
        .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] obs_vec();
        return {pix_erase, pix_expose, pix_convert, ramp_code, out_valid, out_row, out_last, frame_done, busy};
    endfunction

    // Expected control outputs t cycles after the edge that sampled start.
    function automatic logic [12:0] exp_vec(input int t);
        logic er, ex, cv, vl, lst, dn, bs;
        logic [DW-1:0] rc;
        logic [RW-1:0] rw;
        er  = (t >= 1) && (t < T_EXP);
        ex  = (t >= T_EXP) && (t < T_CONV);
        cv  = (t >= T_CONV) && (t < T_LATCH);
        rc  = cv ? DW'(t - T_CONV) : '0;
        vl  = (t >= T_RD) && (t < T_DONE);
        rw  = vl ? RW'(t - T_RD) : '0;
        lst = (t == T_DONE - 1);
        dn  = (t == T_DONE);
        bs  = (t >= 1) && (t < T_DONE);
        return {er, ex, cv, rc, vl, rw, lst, dn, bs};
    endfunction

    task automatic push_frame(input img_t img, input bit tp, input int fc);
        beat_t b;
        for (int r = 0; r < H; r++) begin
            b.row  = RW'(r);
            b.last = (r == H - 1);
            for (int c = 0; c < W; c++)
                b.dat[c*DW +: DW] = tp ? DW'(r + c + fc) : img[(r*W + c)*DW +: DW];
            sb_q.push_back(b);
        end
    endtask

    task automatic run_frame(input img_t img, input int stray, input bit tp, input int fc);
        pix_data  = img;
        push_frame(img, tp, fc);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= T_DONE; t++) begin
            check($sformatf("seq_t%0d", t), obs_vec(), exp_vec(t));
            start = (t == stray);
            if (t == T_RD) pix_data = '1;
            tick();
        end
        start = 1'b0;
    endtask

    // Accepted beats are scored at the falling edge before the accepting rising edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            beats++;
            check("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                check($sformatf("beat_row%0d", sb_q[0].row), {out_row, out_last, out_data}, sb_q[0]);
                void'(sb_q.pop_front());
            end
        end
        if (stall_p && reset === 1'b1)
            check("stall_hold", {out_valid, out_row, out_last, out_data}, snap);
        stall_p <= (reset === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b0);
        snap    <= {out_valid, out_row, out_last, out_data};
    end

    initial begin
        img_t img1, img2;
        bit   seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   b0, d1, d2;

        reset = 1'b0; start = 1'b0; continuous = 1'b0; test_mode = 1'b0;
        out_ready = 1'b1; pix_data = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img1[(r*W + c)*DW +: DW] = DW'(4*r + c);
        img2 = img_t'({$urandom(), $urandom()});

        repeat (3) tick();
        check("rst_ctrl", obs_vec(), '0);
        check("rst_data", out_data, '0);
        reset = 1'b1;
        tick();

        // Single shot with full timing, post-latch pix_data change.
        run_frame(img1, 0, 1'b0, 0);
        check("frame1_beats", beats, H);

        // Backpressure during readout.
        pix_data = img2;
        push_frame(img2, 1'b0, 0);
        b0 = beats;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < T_RD; t++) tick();
        check("stall_rd_entry", {out_valid, out_row}, {1'b1, RW'(0)});
        for (int i = 0; i < 5; i++) begin
            out_ready = seq[i];
            if (i == 1 || i == 2) check($sformatf("stall_row_i%0d", i), out_row, 1);
            tick();
        end
        check("stall_done", frame_done, 1);
        check("stall_beats", beats - b0, 3);
        out_ready = 1'b1;
        tick();

        // Continuous mode: back-to-back frames.
        pix_data = img1;
        push_frame(img1, 1'b0, 0);
        push_frame(img1, 1'b0, 0);
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        d1 = -1;
        d2 = -1;
        for (int cyc = 1; cyc <= 3 * FRAME_PERIOD && d2 < 0; cyc++) begin
            if (frame_done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    check("cont_erase_reentry", {pix_erase, busy}, 2'b11);
                    continuous = 1'b0;
                end else begin
                    d2 = cyc;
                end
            end
            if (d2 < 0) tick();
        end
        check("cont_first_done", d1, T_DONE);
        check("cont_period", d2 - d1, FRAME_PERIOD);
        check("cont_idle", busy, 0);
        tick();

        // Reset mid-conversion, then a stray start while busy.
        pix_data = img1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < T_CONV + 7; t++) tick();
        check("abort_ramp", {pix_convert, ramp_code}, {1'b1, DW'(7)});
        reset = 1'b0;
        tick();
        check("abort_ctrl", obs_vec(), '0);
        check("abort_data", out_data, '0);
        reset = 1'b1;
        tick();
        run_frame(img2, 10, 1'b0, 0);

`ifdef PIXEL_READOUT_TESTPATTERN_EN
        test_mode = 1'b1;
        run_frame(img1, 0, 1'b1, 1);
        test_mode = 1'b0;
`endif

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
